// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/enable controller for the 5-stage pipeline registers
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_stall,
    input  logic       d_stall,
    input  logic       excpt_m,
    input  logic       div_e,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       branch_d,
    input  logic       regwrite_e,
    input  logic       memtoreg_e,
    input  logic [4:0] writereg_e,
    input  logic       memtoreg_m,
    input  logic [4:0] writereg_m,
    output logic       en_pc,
    output logic       en_fd,
    output logic       en_de,
    output logic       en_em,
    output logic       en_mw,
    output logic       clr_fd,
    output logic       clr_de,
    output logic       clr_em,
    output logic       clr_mw,
    output logic       div_start,
    output logic       div_cancel,
    output logic       div_done
);
    localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_DIV        = 2'd1,
        S_DIV_HOLD   = 2'd2,
        S_FLUSH_PEND = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_pend_q, div_pend_d;

    logic mem_stall, e_match, m_match, hazard_d, in_div, flush;

    assign mem_stall = i_stall | d_stall;
    // A destination of $0 never creates a dependence
    assign e_match   = (writereg_e != 5'd0) && ((writereg_e == rs_d) || (writereg_e == rt_d));
    assign m_match   = (writereg_m != 5'd0) && ((writereg_m == rs_d) || (writereg_m == rt_d));
    assign hazard_d  = (regwrite_e & memtoreg_e & e_match) |
                       (branch_d & ((regwrite_e & e_match) | (memtoreg_m & m_match)));
    assign in_div    = (state_q == S_DIV) || (state_q == S_DIV_HOLD);
    assign flush     = excpt_m || (state_q == S_FLUSH_PEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            div_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_pend_q <= div_pend_d;
        end
    end

    always_comb begin
        en_pc      = 1'b1;
        en_fd      = 1'b1;
        en_de      = 1'b1;
        en_em      = 1'b1;
        en_mw      = 1'b1;
        clr_fd     = 1'b0;
        clr_de     = 1'b0;
        clr_em     = 1'b0;
        clr_mw     = 1'b0;
        div_start  = 1'b0;
        div_cancel = 1'b0;
        div_done   = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_pend_d = div_pend_q;

        if (!rst) begin
            // The divider keeps counting even while the pipeline is frozen
            if (state_q == S_DIV && cnt_q != '0)
                cnt_d = cnt_q - 1'b1;

            if (mem_stall) begin
                en_pc = 1'b0;
                en_fd = 1'b0;
                en_de = 1'b0;
                en_em = 1'b0;
                en_mw = 1'b0;
                if (flush) begin
                    state_d    = S_FLUSH_PEND;
                    div_pend_d = div_pend_q | in_div;
                    cnt_d      = '0;
                end else if (state_q == S_DIV && cnt_q == '0) begin
                    state_d = S_DIV_HOLD;
                end
            end else if (flush) begin
                clr_fd     = 1'b1;
                clr_de     = 1'b1;
                clr_em     = 1'b1;
                clr_mw     = 1'b1;
                div_cancel = in_div | ((state_q == S_FLUSH_PEND) & div_pend_q);
                state_d    = S_RUN;
                cnt_d      = '0;
                div_pend_d = 1'b0;
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (div_e) begin
                            div_start = 1'b1;
                            en_pc     = 1'b0;
                            en_fd     = 1'b0;
                            en_de     = 1'b0;
                            clr_em    = 1'b1;
                            cnt_d     = CW'(DIV_CYCLES - 1);
                            state_d   = S_DIV;
                        end else if (hazard_d) begin
                            en_pc  = 1'b0;
                            en_fd  = 1'b0;
                            clr_de = 1'b1;
                        end
                    end
                    S_DIV: begin
                        if (cnt_q != '0) begin
                            en_pc  = 1'b0;
                            en_fd  = 1'b0;
                            en_de  = 1'b0;
                            clr_em = 1'b1;
                        end else begin
                            div_done = 1'b1;
                            state_d  = S_RUN;
                        end
                    end
                    S_DIV_HOLD: begin
                        div_done = 1'b1;
                        state_d  = S_RUN;
                    end
                    default: state_d = S_RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench for pipe_hazard_ctrl with DIV_CYCLES=4
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst, i_stall, d_stall, excpt_m, div_e, branch_d;
    logic       regwrite_e, memtoreg_e, memtoreg_m;
    logic [4:0] rs_d, rt_d, writereg_e, writereg_m;
    logic       en_pc, en_fd, en_de, en_em, en_mw;
    logic       clr_fd, clr_de, clr_em, clr_mw;
    logic       div_start, div_cancel, div_done;

    int tests_run = 0;
    int tests_failed = 0;

    // {en_pc,en_fd,en_de,en_em,en_mw, clr_fd,clr_de,clr_em,clr_mw, div_start,div_cancel,div_done}
    localparam logic [11:0] ADV    = 12'b11111_0000_000;
    localparam logic [11:0] HAZ    = 12'b00111_0100_000;
    localparam logic [11:0] DSTART = 12'b00011_0010_100;
    localparam logic [11:0] DSTALL = 12'b00011_0010_000;
    localparam logic [11:0] DDONE  = 12'b11111_0000_001;
    localparam logic [11:0] FRZ    = 12'b00000_0000_000;
    localparam logic [11:0] FLSH   = 12'b11111_1111_000;
    localparam logic [11:0] FLSHC  = 12'b11111_1111_010;

    logic [11:0] obs;
    assign obs = {en_pc, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw,
                  div_start, div_cancel, div_done};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall), .excpt_m(excpt_m),
        .div_e(div_e), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
        .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .writereg_e(writereg_e),
        .memtoreg_m(memtoreg_m), .writereg_m(writereg_m),
        .en_pc(en_pc), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
        .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em), .clr_mw(clr_mw),
        .div_start(div_start), .div_cancel(div_cancel), .div_done(div_done)
    );

    // Inputs are set 1 time unit after a rising edge; outputs are checked 1 unit later
    task automatic step(input string tag, input logic [11:0] exp);
        #1;
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_stall = 0; d_stall = 0; excpt_m = 0; div_e = 0; branch_d = 0;
        regwrite_e = 0; memtoreg_e = 0; memtoreg_m = 0;
        rs_d = 0; rt_d = 0; writereg_e = 0; writereg_m = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1; i_stall = 1; div_e = 1; excpt_m = 1;
        @(posedge clk); #1;
        step("reset_outputs", ADV);
        rst = 0; idle_inputs();
        step("idle_advance", ADV);

        regwrite_e = 1; memtoreg_e = 1; writereg_e = 5; rs_d = 5;
        step("load_use_stall", HAZ);
        regwrite_e = 0; memtoreg_e = 0; memtoreg_m = 1; writereg_m = 5;
        step("load_use_released", ADV);
        idle_inputs();
        regwrite_e = 1; memtoreg_e = 1; writereg_e = 0; rs_d = 0;
        step("load_to_r0_no_stall", ADV);

        idle_inputs();
        branch_d = 1; rt_d = 7; memtoreg_m = 1; writereg_m = 7;
        step("branch_load_in_m", HAZ);
        memtoreg_m = 0;
        step("branch_after_load", ADV);
        regwrite_e = 1; writereg_e = 7;
        step("branch_alu_in_e", HAZ);
        regwrite_e = 0;
        step("branch_after_alu", ADV);
        branch_d = 0; regwrite_e = 1; writereg_e = 7;
        step("alu_dep_no_branch", ADV);

        idle_inputs();
        div_e = 1;
        step("div_start", DSTART);
        regwrite_e = 1; memtoreg_e = 1; writereg_e = 3; rs_d = 3;
        step("div_t1_hazard_ignored", DSTALL);
        step("div_t2", DSTALL);
        step("div_t3", DSTALL);
        step("div_done_t4", DDONE);
        idle_inputs();
        step("div_after_done", ADV);

        div_e = 1;
        step("divh_start", DSTART);
        step("divh_t1", DSTALL);
        step("divh_t2", DSTALL);
        d_stall = 1;
        step("divh_t3_freeze", FRZ);
        step("divh_t4_freeze", FRZ);
        step("divh_t5_freeze", FRZ);
        step("divh_t6_freeze", FRZ);
        d_stall = 0;
        step("divh_done_t7", DDONE);
        div_e = 0;
        step("divh_after", ADV);

        i_stall = 1; excpt_m = 1;
        step("exc_freeze_1", FRZ);
        step("exc_freeze_2", FRZ);
        step("exc_freeze_3", FRZ);
        i_stall = 0; excpt_m = 0;
        step("exc_deferred_flush", FLSH);
        step("exc_after_flush", ADV);

        div_e = 1;
        step("dexc_start", DSTART);
        step("dexc_t1", DSTALL);
        excpt_m = 1;
        step("dexc_cancel_t2", FLSHC);
        excpt_m = 0; div_e = 0;
        step("dexc_t3", ADV);
        step("dexc_t4_no_done", ADV);

        div_e = 1; excpt_m = 1;
        step("div_and_exc_same", FLSH);
        div_e = 0; excpt_m = 0;
        step("div_and_exc_after", ADV);

        div_e = 1;
        step("dz_start", DSTART);
        step("dz_t1", DSTALL);
        step("dz_t2", DSTALL);
        step("dz_t3", DSTALL);
        excpt_m = 1;
        step("dz_exc_at_zero", FLSHC);
        excpt_m = 0; div_e = 0;
        step("dz_after", ADV);

        div_e = 1;
        step("dp_start", DSTART);
        d_stall = 1; excpt_m = 1;
        step("dp_freeze_exc", FRZ);
        excpt_m = 0;
        step("dp_freeze", FRZ);
        d_stall = 0; div_e = 0;
        step("dp_pending_cancel", FLSHC);
        step("dp_after", ADV);

        div_e = 1;
        step("dr_start", DSTART);
        step("dr_t1", DSTALL);
        rst = 1;
        step("dr_reset_mid_div", ADV);
        rst = 0; div_e = 0;
        step("dr_after_reset", ADV);
        step("dr_no_done", ADV);

        i_stall = 1; excpt_m = 1;
        step("fr_freeze_exc", FRZ);
        rst = 1; excpt_m = 0;
        step("fr_reset_in_pend", ADV);
        rst = 0; i_stall = 0;
        step("fr_no_flush_after_reset", ADV);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and stall/flush controller for the 5-stage MIPS core. It drives the enable and clear inputs of every pipeline register (PC, F/D, D/E, E/M, M/W) from four sources: memory-bus stalls, M-stage exceptions, the multi-cycle divider, and D-stage data hazards. Control outputs are combinational so they take effect in the current cycle. A registered FSM tracks multi-cycle events: divider occupancy and flushes deferred across bus stalls.

## Interface
Parameters:
- DIV_CYCLES, 32, divider latency in cycles from `div_start` to result valid (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_stall  in  1  instruction-side bus transaction outstanding
- d_stall  in  1  data-side bus transaction outstanding
- excpt_m  in  1  exception taken by instruction in M
- div_e  in  1  DIV/DIVU instruction in E
- rs_d, rt_d  in  5  D-stage source registers
- branch_d  in  1  branch/jump-register in D (compares in D)
- regwrite_e, memtoreg_e  in  1  E-stage writes a register / is a load
- writereg_e  in  5  E-stage destination
- memtoreg_m  in  1  M-stage is a load
- writereg_m  in  5  M-stage destination
- en_pc, en_fd, en_de, en_em, en_mw  out  1  register enables
- clr_fd, clr_de, clr_em, clr_mw  out  1  register clears (bubble insert)
- div_start  out  1  one-cycle divider launch pulse
- div_cancel  out  1  one-cycle divider abort pulse
- div_done  out  1  divider result accepted this cycle

## Operation
- Define mem_stall = i_stall | d_stall.
- hazard_d: either of the following holds, and the matched destination register is non-zero:
  - regwrite_e & memtoreg_e & writereg_e ∈ {rs_d, rt_d} (load-use);
  - branch_d & ((regwrite_e & writereg_e ∈ {rs_d, rt_d}) | (memtoreg_m & writereg_m ∈ {rs_d, rt_d})).
- Default output set is "advance": all en=1, all clr=0, and all pulses=0.
- The FSM has four states: RUN, DIV, DIV_HOLD, FLUSH_PEND. It resets to RUN.
- Priority, highest first: rst, mem_stall, exception/pending flush, divider, hazard_d.
- **Freeze.** When mem_stall=1 in any state, all en=0, all clr=0, and div_start=0.
  - excpt_m=1 during a freeze moves the FSM to FLUSH_PEND.
  - In DIV, a freeze does not pause the divider counter.
- **Flush.** Triggered by excpt_m=1 with mem_stall=0, or by FLUSH_PEND with mem_stall=0.
  - All en=1; clr_fd=clr_de=clr_em=clr_mw=1.
  - Next state is RUN.
  - If the flush occurs while the FSM is in DIV or DIV_HOLD, div_cancel=1 and the counter is discarded.
  - FLUSH_PEND also records whether a divide was in flight, so div_cancel still fires.
- **RUN.**
  - div_e=1 with no freeze and no flush: div_start=1, counter loads DIV_CYCLES-1, next state DIV.
  - The same cycle applies the divider stall pattern: en_pc=en_fd=en_de=0, en_em=1, clr_em=1.
  - Otherwise, if hazard_d=1: en_pc=en_fd=0, clr_de=1, and the rest advance.
- **DIV.**
  - The counter decrements every cycle.
  - While the counter is non-zero, apply the divider stall pattern.
  - When the counter is 0:
    - with mem_stall=0: div_done=1, all stages advance, next state RUN;
    - with mem_stall=1: next state DIV_HOLD.
- **DIV_HOLD.** Frozen while mem_stall=1. On the first cycle with mem_stall=0: div_done=1, advance, next state RUN.
- hazard_d is ignored while the FSM is in DIV or DIV_HOLD, because D is already stalled.

## Timing
- Reset values: state=RUN, counter=0, flush-pending=0, div-pending=0.
  - During the rst cycle the outputs are the advance set with all pulses 0.
- All en/clr outputs are combinational from the current state and the inputs in the same cycle.
- Divide latency: div_start at cycle T; div_done at cycle T+DIV_CYCLES when there is no freeze.
  - D/E holds the DIV instruction for cycles T through T+DIV_CYCLES-1.
- A load-use stall inserts exactly one bubble: hazard_d clears once the load reaches M.
- A branch that depends on a load in M stalls one more cycle.
- div_e and excpt_m in the same cycle: the flush wins. No div_start is issued and no div_cancel (nothing was in flight).
- An exception arriving in the same cycle that the counter reaches 0: the flush wins. div_cancel=1, div_done=0.
- rst asserted mid-divide or in FLUSH_PEND: returns to RUN next cycle with no pulses.

## Test plan
- **Load-use:** lw $5 in E (memtoreg_e=1, regwrite_e=1, writereg_e=5), rs_d=5 -> en_pc=en_fd=0, clr_de=1 for 1 cycle, then advance. Repeat with writereg_e=0 -> no stall.
- **Divide, DIV_CYCLES=4:** div_e=1 at T -> div_start at T; clr_em=1 at T..T+3; div_done at T+4; en_de=1 at T+4.
- **Divide with bus stall:** d_stall=1 over T+3..T+6 -> DIV_HOLD entered, all outputs frozen; div_done exactly once at T+7.
- **Exception during freeze:** excpt_m=1 with i_stall=1 for 3 cycles -> en all 0 during the freeze; all four clr=1 on the first cycle i_stall=0; clr=0 afterwards.
- **Exception mid-divide:** excpt_m at T+2 -> div_cancel=1 and all clr=1 at T+2; div_done never asserts; state RUN.
- **Branch hazard:** branch_d=1, rt_d=7, load in M to $7 -> 1-cycle stall. Same branch with ALU write of $7 in E -> 1-cycle stall.
